// File: rtl/core_launcher_if.sv
// Host-side command and image-stream handshake bundle for core_launcher.
// master = host/testbench, slave = launcher.
interface core_launcher_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_insn_len;
    logic [15:0] cmd_data_len;
    logic [31:0] cmd_max_cycles;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;

    modport master (
        output cmd_valid, cmd_insn_len, cmd_data_len, cmd_max_cycles, s_valid, s_data,
        input  cmd_ready, s_ready
    );

    modport slave (
        input  cmd_valid, cmd_insn_len, cmd_data_len, cmd_max_cycles, s_valid, s_data,
        output cmd_ready, s_ready
    );
endinterface

// File: rtl/core_launcher.sv
// Loads an instruction/data image into a core, runs it until a UART halt code or cycle limit.
// Optional abort input/aborted flag enabled by defining CORE_LAUNCHER_ABORT_EN.
module core_launcher #(
    parameter int unsigned ADDR_W    = 12,
    parameter logic [31:0] HALT_CODE = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             reset,
    core_launcher_if.slave   host,
    output logic             core_reset,
    output logic             core_run,
    output logic [31:0]      insn_addr,
    output logic [31:0]      insn_din,
    output logic             insn_we,
    output logic [31:0]      data_addr,
    output logic [31:0]      data_din,
    output logic             data_we,
    input  logic [31:0]      uart_dout,
    input  logic             uart_we,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [31:0]      cycles
`ifdef CORE_LAUNCHER_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

    typedef enum logic [2:0] {StIdle, StLoadI, StLoadD, StGap, StRun, StFinish} state_t;

    state_t      state_q, state_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] insn_len_q, insn_len_d, data_len_q, data_len_d;
    logic [31:0] max_q, max_d;
    logic [31:0] cycles_q, cycles_d;
    logic        timeout_q, timeout_d;
    logic        aborted_q, aborted_d;
    logic        cmd_ready_q, s_ready_q, core_reset_q, core_run_q, busy_q, done_q;
    logic        cmd_ready_d, s_ready_d, core_reset_d, core_run_d, busy_d, done_d;
    logic        insn_we_q, insn_we_d, data_we_q, data_we_d;
    logic [31:0] insn_addr_q, insn_addr_d, insn_din_q, insn_din_d;
    logic [31:0] data_addr_q, data_addr_d, data_din_q, data_din_d;

    logic hs, in_range, halt, limit;

    always_comb begin
        hs       = host.s_valid && s_ready_q;
        in_range = ({17'd0, idx_q} < DEPTH);
        halt     = uart_we && (uart_dout == HALT_CODE);
        limit    = (max_q != 32'd0) && (({1'b0, cycles_q} + 33'd1) == {1'b0, max_q});

        state_d     = state_q;
        idx_d       = idx_q;
        insn_len_d  = insn_len_q;
        data_len_d  = data_len_q;
        max_d       = max_q;
        cycles_d    = cycles_q;
        timeout_d   = timeout_q;
        aborted_d   = aborted_q;
        insn_we_d   = 1'b0;
        insn_addr_d = insn_addr_q;
        insn_din_d  = insn_din_q;
        data_we_d   = 1'b0;
        data_addr_d = data_addr_q;
        data_din_d  = data_din_q;

        unique case (state_q)
            StIdle: begin
                if (host.cmd_valid && cmd_ready_q) begin
                    insn_len_d = host.cmd_insn_len;
                    data_len_d = host.cmd_data_len;
                    max_d      = host.cmd_max_cycles;
                    cycles_d   = 32'd0;
                    timeout_d  = 1'b0;
                    aborted_d  = 1'b0;
                    idx_d      = 16'd0;
                    if (host.cmd_insn_len != 16'd0)      state_d = StLoadI;
                    else if (host.cmd_data_len != 16'd0) state_d = StLoadD;
                    else                                 state_d = StGap;
                end
            end
            StLoadI: begin
                if (hs) begin
                    // Words beyond the memory depth are swallowed without a write.
                    insn_we_d = in_range;
                    if (in_range) begin
                        insn_addr_d = {14'd0, idx_q, 2'b00};
                        insn_din_d  = host.s_data;
                    end
                    if (idx_q == insn_len_q - 16'd1) begin
                        idx_d   = 16'd0;
                        state_d = (data_len_q != 16'd0) ? StLoadD : StGap;
                    end else begin
                        idx_d = idx_q + 16'd1;
                    end
                end
            end
            StLoadD: begin
                if (hs) begin
                    data_we_d = in_range;
                    if (in_range) begin
                        data_addr_d = {14'd0, idx_q, 2'b00};
                        data_din_d  = host.s_data;
                    end
                    if (idx_q == data_len_q - 16'd1) begin
                        idx_d   = 16'd0;
                        state_d = StGap;
                    end else begin
                        idx_d = idx_q + 16'd1;
                    end
                end
            end
            StGap: state_d = StRun;
            StRun: begin
                cycles_d = (cycles_q == 32'hFFFF_FFFF) ? cycles_q : cycles_q + 32'd1;
                if (halt) begin
                    state_d = StFinish;
                end else if (limit) begin
                    state_d   = StFinish;
                    timeout_d = 1'b1;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

`ifdef CORE_LAUNCHER_ABORT_EN
        // Abort overrides everything, including a halt in the same cycle.
        if (abort && (state_q != StIdle) && (state_q != StFinish)) begin
            state_d     = StFinish;
            aborted_d   = 1'b1;
            timeout_d   = timeout_q;
            idx_d       = idx_q;
            insn_we_d   = 1'b0;
            insn_addr_d = insn_addr_q;
            insn_din_d  = insn_din_q;
            data_we_d   = 1'b0;
            data_addr_d = data_addr_q;
            data_din_d  = data_din_q;
        end
`endif

        cmd_ready_d  = (state_d == StIdle);
        s_ready_d    = (state_d == StLoadI) || (state_d == StLoadD);
        core_reset_d = !((state_d == StRun) || (state_d == StFinish));
        core_run_d   = (state_d == StRun);
        busy_d       = (state_d != StIdle);
        done_d       = (state_d == StFinish);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            idx_q        <= 16'd0;
            insn_len_q   <= 16'd0;
            data_len_q   <= 16'd0;
            max_q        <= 32'd0;
            cycles_q     <= 32'd0;
            timeout_q    <= 1'b0;
            aborted_q    <= 1'b0;
            cmd_ready_q  <= 1'b1;
            s_ready_q    <= 1'b0;
            core_reset_q <= 1'b1;
            core_run_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            insn_we_q    <= 1'b0;
            insn_addr_q  <= 32'd0;
            insn_din_q   <= 32'd0;
            data_we_q    <= 1'b0;
            data_addr_q  <= 32'd0;
            data_din_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            insn_len_q   <= insn_len_d;
            data_len_q   <= data_len_d;
            max_q        <= max_d;
            cycles_q     <= cycles_d;
            timeout_q    <= timeout_d;
            aborted_q    <= aborted_d;
            cmd_ready_q  <= cmd_ready_d;
            s_ready_q    <= s_ready_d;
            core_reset_q <= core_reset_d;
            core_run_q   <= core_run_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            insn_we_q    <= insn_we_d;
            insn_addr_q  <= insn_addr_d;
            insn_din_q   <= insn_din_d;
            data_we_q    <= data_we_d;
            data_addr_q  <= data_addr_d;
            data_din_q   <= data_din_d;
        end
    end

    assign host.cmd_ready = cmd_ready_q;
    assign host.s_ready   = s_ready_q;
    assign core_reset     = core_reset_q;
    assign core_run       = core_run_q;
    assign insn_addr      = insn_addr_q;
    assign insn_din       = insn_din_q;
    assign insn_we        = insn_we_q;
    assign data_addr      = data_addr_q;
    assign data_din       = data_din_q;
    assign data_we        = data_we_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign timeout        = timeout_q;
    assign cycles         = cycles_q;
`ifdef CORE_LAUNCHER_ABORT_EN
    assign aborted        = aborted_q;
`else
    logic unused_aborted;
    assign unused_aborted = aborted_q;
`endif

endmodule

// File: tb/tb_core_launcher.sv
// Randomized self-checking bench for core_launcher (small ADDR_W to exercise discard).
// Expected writes and run lengths come from the command parameters directly.
module tb_core_launcher;
    localparam int unsigned ADDR_W = 2;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_reset, core_run, insn_we, data_we, busy, done, timeout;
    logic [31:0] insn_addr, insn_din, data_addr, data_din, cycles;
    logic [31:0] uart_dout;
    logic        uart_we;

    core_launcher_if host ();

    core_launcher #(.ADDR_W(ADDR_W), .HALT_CODE(HALT)) dut (
        .clk(clk), .reset(reset), .host(host),
        .core_reset(core_reset), .core_run(core_run),
        .insn_addr(insn_addr), .insn_din(insn_din), .insn_we(insn_we),
        .data_addr(data_addr), .data_din(data_din), .data_we(data_we),
        .uart_dout(uart_dout), .uart_we(uart_we),
        .busy(busy), .done(done), .timeout(timeout), .cycles(cycles)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: records every write and done pulse seen at the negedge.
    logic [63:0] iw_q[$];
    logic [63:0] dw_q[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (insn_we) iw_q.push_back({insn_addr, insn_din});
        if (data_we) dw_q.push_back({data_addr, data_din});
        if (done) done_cnt++;
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "/flags"},
                 {host.cmd_ready, host.s_ready, core_reset, core_run, insn_we, data_we,
                  busy, done, timeout}, 64'b101000000);
        check_eq({tag, "/insn"}, {insn_addr, insn_din}, 64'd0);
        check_eq({tag, "/data"}, {data_addr, data_din}, 64'd0);
        check_eq({tag, "/cycles"}, cycles, 64'd0);
    endtask

    task automatic run_cmd(input int ilen, input int dlen, input logic [31:0] maxc,
                           input int halt_at, input bit toggle);
        logic [31:0] w[$];
        int          total, idx, guard, run_seen, exp_run, n_i, n_d;
        bit          exp_to, sv;

        total = ilen + dlen;
        for (int i = 0; i < total; i++) w.push_back($urandom);
        // Halt counts only if it lands no later than the limit.
        if (halt_at != 0 && (maxc == 0 || halt_at <= int'(maxc))) begin
            exp_run = halt_at;
            exp_to  = 1'b0;
        end else begin
            exp_run = int'(maxc);
            exp_to  = 1'b1;
        end
        n_i = (ilen < DEPTH) ? ilen : DEPTH;
        n_d = (dlen < DEPTH) ? dlen : DEPTH;

        iw_q.delete();
        dw_q.delete();
        done_cnt = 0;

        check_eq("cmd_ready", host.cmd_ready, 1);
        host.cmd_valid      = 1'b1;
        host.cmd_insn_len   = 16'(ilen);
        host.cmd_data_len   = 16'(dlen);
        host.cmd_max_cycles = maxc;
        @(negedge clk);
        host.cmd_valid = 1'b0;
        check_eq("busy_accept", busy, 1);

        idx   = 0;
        guard = 0;
        sv    = 1'b0;
        while (idx < total && guard < 200) begin
            sv            = toggle ? ~sv : 1'b1;
            host.s_valid  = sv;
            host.s_data   = w[idx];
            if (sv && host.s_ready) idx++;
            @(negedge clk);
            guard++;
        end
        check_eq("load_words", idx, total);

        // Stray stream traffic after the load must be ignored.
        host.s_valid = 1'b1;
        host.s_data  = $urandom;
        check_eq("gap", {host.s_ready, core_reset, core_run, busy}, 4'b0101);
        @(negedge clk);

        run_seen = 0;
        guard    = 0;
        while (core_run && guard < 300) begin
            run_seen++;
            if (run_seen == halt_at) begin
                uart_we   = 1'b1;
                uart_dout = HALT;
            end else begin
                uart_we   = 1'($urandom);
                uart_dout = $urandom & 32'h7FFF_FFFF;
            end
            @(negedge clk);
            guard++;
        end
        uart_we = 1'b0;
        check_eq("run_len", run_seen, exp_run);
        check_eq("finish", {done, core_run, core_reset}, 3'b100);
        check_eq("cycles", cycles, exp_run);
        check_eq("timeout", timeout, exp_to);
        @(negedge clk);
        check_eq("idle", {done, host.cmd_ready, core_reset, busy}, 4'b0110);
        check_eq("cycles_hold", cycles, exp_run);
        check_eq("timeout_hold", timeout, exp_to);
        host.s_valid = 1'b0;

        check_eq("done_pulses", done_cnt, 1);
        check_eq("insn_count", iw_q.size(), n_i);
        for (int i = 0; i < n_i && i < iw_q.size(); i++)
            check_eq("insn_wr", iw_q[i], {32'(i * 4), w[i]});
        check_eq("data_count", dw_q.size(), n_d);
        for (int j = 0; j < n_d && j < dw_q.size(); j++)
            check_eq("data_wr", dw_q[j], {32'(j * 4), w[ilen + j]});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int il, dl, hl;
        logic [31:0] mx;

        reset               = 1'b1;
        host.cmd_valid      = 1'b0;
        host.cmd_insn_len   = 16'd0;
        host.cmd_data_len   = 16'd0;
        host.cmd_max_cycles = 32'd0;
        host.s_valid        = 1'b0;
        host.s_data         = 32'd0;
        uart_we             = 1'b0;
        uart_dout           = 32'd0;

        do_reset();
        check_reset_vals("reset");

        run_cmd(3, 2, 32'd0, 5, 1'b0);   // basic image then halt
        run_cmd(2, 0, 32'd10, 0, 1'b0);  // cycle limit
        run_cmd(0, 0, 32'd0, 3, 1'b0);   // empty image
        run_cmd(4, 0, 32'd0, 2, 1'b1);   // stalling stream
        run_cmd(1, 1, 32'd7, 7, 1'b0);   // halt and limit together
        run_cmd(6, 0, 32'd0, 4, 1'b0);   // overflow discard
        run_cmd(2, 6, 32'd1, 0, 1'b0);   // limit of one cycle

        // Reset in the middle of an instruction load.
        host.cmd_valid    = 1'b1;
        host.cmd_insn_len = 16'd5;
        host.cmd_data_len = 16'd0;
        @(negedge clk);
        host.cmd_valid = 1'b0;
        host.s_valid   = 1'b1;
        host.s_data    = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        host.s_valid = 1'b0;
        do_reset();
        check_reset_vals("mid_reset");
        run_cmd(2, 1, 32'd0, 3, 1'b0);

        for (int k = 0; k < 12; k++) begin
            il = $urandom_range(0, 6);
            dl = $urandom_range(0, 6);
            mx = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 20));
            hl = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20);
            if (mx == 0 && hl == 0) hl = 1;
            run_cmd(il, dl, mx, hl, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
